// File: rtl/div_unit.sv
// div_unit: multicycle signed divider for the DIV instruction.
// Restoring division runs on operand magnitudes, one quotient bit per
// cycle, and a final cycle applies the sign fix-up. The quotient truncates
// toward zero and the remainder takes the sign of the dividend.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,       // synchronous, active-low
    input  logic             divControl,
    input  logic [WIDTH-1:0] divA,
    input  logic [WIDTH-1:0] divB,
    output logic [WIDTH-1:0] divHI,
    output logic [WIDTH-1:0] divLO,
    output logic             divBusy,
    output logic             divDone,
    output logic             zeroDiv
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;      // one spare bit holds the shifted-out MSB
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH+1:0] w_trial;
    logic             w_trial_ok;

    // Magnitudes are unsigned, so |most-negative| stays representable.
    assign w_abs_a = divA[WIDTH-1] ? -divA : divA;
    assign w_abs_b = divB[WIDTH-1] ? -divB : divB;

    // One restoring step: shift {rem, quo} left and try to subtract.
    // The extra top bit of the trial is its sign.
    assign w_shift_rem = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial     = {1'b0, w_shift_rem} - {2'b00, r_dvs};
    assign w_trial_ok  = ~w_trial[WIDTH+1];

    // Control FSM, datapath registers and registered outputs.
    // NOTE: state is written with <= only, so every reader in this block
    // sees the value from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_zero <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (divControl) begin
                        if (divB == '0) begin
                            r_zero <= 1'b1;
                        end else begin
                            r_qneg  <= divA[WIDTH-1] ^ divB[WIDTH-1];
                            r_rneg  <= divA[WIDTH-1];
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_trial_ok) begin
                        r_rem <= w_trial[WIDTH:0];
                    end else begin
                        r_rem <= w_shift_rem;
                    end
                    r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_qneg ? -r_quo : r_quo;
                    r_hi    <= r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign divHI   = r_hi;
    assign divLO   = r_lo;
    assign divBusy = r_busy;
    assign divDone = r_done;
    assign zeroDiv = r_zero;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test of div_unit against a transaction-level model.
// The model computes results with 64-bit signed arithmetic and tracks when
// each result is due; a compare process checks every output each cycle.
module tb_div_unit;

    localparam int W       = 32;
    localparam int LATENCY = 33;

    logic         clk;
    logic         reset;
    logic         divControl;
    logic [W-1:0] divA;
    logic [W-1:0] divB;
    logic [W-1:0] divHI;
    logic [W-1:0] divLO;
    logic         divBusy;
    logic         divDone;
    logic         zeroDiv;

    int n_checks;
    int n_fail;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .divA       (divA),
        .divB       (divB),
        .divHI      (divHI),
        .divLO      (divLO),
        .divBusy    (divBusy),
        .divDone    (divDone),
        .zeroDiv    (zeroDiv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // MIPS DIV semantics from plain signed arithmetic, wrapped to 32 bits.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return q[W-1:0];
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sa % sb;
        return r[W-1:0];
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;
    logic         exp_busy, exp_done, exp_zero;
    int           busy_left;
    bit           cmp_en;

    always @(posedge clk) begin
        if (!reset) begin
            busy_left = 0;
            exp_hi    = '0;
            exp_lo    = '0;
            exp_done  = 1'b0;
            exp_zero  = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_zero = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    exp_hi   = pend_hi;
                    exp_lo   = pend_lo;
                    exp_done = 1'b1;
                end
            end else if (divControl) begin
                if (divB == '0) begin
                    exp_zero = 1'b1;
                end else begin
                    pend_lo   = model_q(divA, divB);
                    pend_hi   = model_r(divA, divB);
                    busy_left = LATENCY;
                end
            end
        end
        exp_busy = (busy_left > 0);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_hi",   divHI,        exp_hi);
            check("cyc_lo",   divLO,        exp_lo);
            check("cyc_busy", W'(divBusy),  W'(exp_busy));
            check("cyc_done", W'(divDone),  W'(exp_done));
            check("cyc_zero", W'(zeroDiv),  W'(exp_zero));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: the following posedge is E0. Returns at the
    // negedge right after E0.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        divA       = a;
        divB       = b;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        divA       = $urandom;  // later operand changes must be ignored
        divB       = $urandom;
    endtask

    // From the negedge after E0, wait for divDone. Returns edges since E0
    // (33 expected) and the number of cycles divBusy was seen high.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!divDone && edges < 40) begin
            if (divBusy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (!divDone) begin
            n_fail++;
            $display("FAIL done_timeout actual=no_done required=done within 40 edges");
        end
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r);
        int e, bc;
        @(negedge clk);
        launch(a, b);
        wait_done(e, bc);
        check({name, "_lat"}, W'(e), W'(LATENCY));
        check({name, "_lo"}, divLO, q);
        check({name, "_hi"}, divHI, r);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e, bc;
        n_checks   = 0;
        n_fail     = 0;
        cmp_en     = 1'b0;
        reset      = 1'b0;
        divControl = 1'b0;
        divA       = '0;
        divB       = '0;

        // Pin the model with hand-computed values.
        check("model_q_m7_2",  model_q(32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        check("model_r_m7_2",  model_r(32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        check("model_q_ovf",   model_q(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_r_7_m2",  model_r(32'h7, 32'hFFFF_FFFE), 32'h1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_hi",   divHI, '0);
        check("rst_lo",   divLO, '0);
        check("rst_busy", W'(divBusy), '0);
        reset = 1'b1;

        // 7 / 2 with busy-length measurement.
        @(negedge clk);
        launch(32'd7, 32'd2);
        wait_done(e, bc);
        check("d7_2_lat",  W'(e),  W'(LATENCY));
        check("d7_2_busy", W'(bc), W'(33));
        check("d7_2_lo",   divLO, 32'h3);
        check("d7_2_hi",   divHI, 32'h1);

        run_div("m7_2", 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("d7_m2", 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);

        // Divide by zero after preloading 2 rem 1.
        run_div("d9_4", 32'd9, 32'd4, 32'd2, 32'd1);
        @(negedge clk);
        launch(32'd55, 32'd0);
        check("z_pulse", W'(zeroDiv), 32'h1);
        check("z_busy",  W'(divBusy), '0);
        @(negedge clk);
        check("z_pulse_end", W'(zeroDiv), '0);
        check("z_done",  W'(divDone), '0);
        check("z_hi",    divHI, 32'h1);
        check("z_lo",    divLO, 32'h2);

        run_div("ovf",    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        run_div("min_1",  32'h8000_0000, 32'd1,         32'h8000_0000, 32'h0);

        // Start 100/7, ignored B=0 pulse at E10, reset at E20.
        @(negedge clk);
        launch(32'd100, 32'd7);              // now at negedge after E0
        repeat (9) @(negedge clk);           // negedge after E9
        divControl = 1'b1;
        divB       = '0;
        @(negedge clk);                      // after E10
        divControl = 1'b0;
        check("ab_no_zero", W'(zeroDiv), '0);
        check("ab_busy",    W'(divBusy), 32'h1);
        repeat (9) @(negedge clk);           // after E19
        reset = 1'b0;
        @(negedge clk);                      // after E20
        reset = 1'b1;
        check("ab_hi",   divHI, '0);
        check("ab_lo",   divLO, '0);
        check("ab_busy_off", W'(divBusy), '0);
        repeat (20) @(negedge clk);
        check("ab_no_done", W'(divDone), '0);
        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);

        // Back-to-back: second start issued in the divDone cycle.
        @(negedge clk);
        launch(32'd1000, 32'd10);
        wait_done(e, bc);
        check("bb1_lat", W'(e), W'(LATENCY));
        check("bb1_lo",  divLO, 32'd100);
        check("bb1_hi",  divHI, 32'd0);
        launch(32'd5, 32'd3);
        wait_done(e, bc);
        check("bb2_lat", W'(e), W'(LATENCY));
        check("bb2_lo",  divLO, 32'd1);
        check("bb2_hi",  divHI, 32'd2);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
